// File: rtl/insn_prefetch.sv
// rtl/insn_prefetch.sv - instruction prefetch FIFO with redirect flush
// Optional starvation counter (stall_cnt port) enabled by defining INSN_PREFETCH_STALLCNT_EN.
module insn_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef INSN_PREFETCH_STALLCNT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn,
    output logic [31:0] insn_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   addr_q [DEPTH];

    logic [CW:0]   pending;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_target;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // Occupancy includes the in-flight response so its slot is reserved before it lands.
    assign pending    = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign imem_req   = !rst && !redirect_valid && (pending < (CW+1)'(DEPTH));
    assign imem_addr  = rst ? RESET_ADDR : pc_q;
    assign insn_valid = !rst && !redirect_valid && (count_q != '0);
    assign insn       = rst ? 32'h0 : data_q[rd_ptr_q];
    assign insn_pc    = rst ? 32'h0 : addr_q[rd_ptr_q];

    assign push = inflight_q && !redirect_valid;
    assign pop  = insn_valid && insn_ready;

    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inflight_d = imem_req;
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        if (imem_req) begin
            pc_d       = pc_q + 32'd4;
            req_addr_d = pc_q;
        end
        // A redirect drops both queued entries and the response still on its way.
        if (redirect_valid) begin
            pc_d       = redirect_target;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_ADDR;
            req_addr_q <= RESET_ADDR;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 32'h0;
                addr_q[i] <= 32'h0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= imem_data;
            addr_q[wr_ptr_q] <= req_addr_q;
        end
    end

`ifdef INSN_PREFETCH_STALLCNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'h0;
        end else if (!insn_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/insn_prefetch.md
INSN_PREFETCH -- requirements
Module: insn_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch FIFO entries; legal values 2, 4, 8.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1: instruction memory read request this cycle.
REQ-006 SHALL have port imem_addr  output  32: word-aligned read address; bits [1:0] always 0.
REQ-007 SHALL have port imem_data  input  32: read data, valid exactly one cycle after the cycle in which imem_req=1.
REQ-008 SHALL have port redirect_valid  input  1: branch/jump redirect strobe.
REQ-009 SHALL have port redirect_pc  input  32: redirect target; bits [1:0] ignored and treated as 0.
REQ-010 SHALL have port insn_valid  output  1: head FIFO entry presented to decode.
REQ-011 SHALL have port insn_ready  input  1: decode accepts; transfer when insn_valid && insn_ready.
REQ-012 SHALL have port insn  output  32: instruction word of head entry.
REQ-013 SHALL have port insn_pc  output  32: address of head entry.
REQ-014 SHALL have port stall_cnt  output  32: starvation counter, present only per REQ-032.

Function
REQ-015 SHALL hold a fetch PC; a request issues at PC when occupancy + in-flight < DEPTH and redirect_valid=0, then PC advances by 4.
REQ-016 SHALL wrap the PC modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000).
REQ-017 SHALL write {imem_data, request address} into the FIFO at the end of the cycle in which the response arrives, unless killed per REQ-021.
REQ-018 SHALL present the FIFO head registered; first insn_valid=1 two cycles after the first post-reset request cycle (request cycle N, data cycle N+1, valid cycle N+2).
REQ-019 SHALL deassert imem_req when FIFO is full or full-pending (occupancy + in-flight == DEPTH); a simultaneous pop does not free a slot for a request in the same cycle.
REQ-020 SHALL allow push and pop in the same cycle with occupancy unchanged, including at full (push legal only because it was reserved by in-flight accounting).
REQ-021 On redirect_valid=1: SHALL flush all FIFO entries, discard any in-flight response arriving the next cycle, load PC with {redirect_pc[31:2],2'b00}, drive imem_req=0 and insn_valid=0 that cycle.
REQ-022 SHALL issue the first request at the redirect target on the cycle after redirect_valid; no pop is counted in the redirect cycle even if insn_ready=1.
REQ-023 Back-to-back redirect cycles: the last one wins; nothing is fetched until redirect_valid falls.
REQ-024 insn/insn_pc SHALL hold stable while insn_valid=1 and insn_ready=0.
REQ-025 Steady state with insn_ready held 1 SHALL deliver one instruction per cycle at consecutive addresses.

Reset
REQ-026 While rst=1: imem_req=0, imem_addr=RESET_PC, insn_valid=0, insn=0, insn_pc=0, FIFO empty, in-flight cleared, PC=RESET_PC.
REQ-027 Reset asserted mid-fetch SHALL discard the in-flight response arriving in the following cycle.
REQ-028 First request SHALL occur in the first cycle with rst=0.
REQ-029 stall_cnt (when present) SHALL reset to 0.

Configuration
REQ-030 Macro INSN_PREFETCH_STALLCNT_EN controls the starvation counter.
REQ-031 Without the macro: no stall_cnt port, no counter logic.
REQ-032 With the macro: stall_cnt increments each cycle rst=0 and insn_valid=0, saturates at 32'hFFFF_FFFF, never cleared by redirect.

Verification
REQ-033 RESET_PC=0x100, memory returns addr^0xA5A5_0000, insn_ready=1 -> requests 0x100,0x104,... from cycle 0; insn_valid from cycle 2; insn_pc 0x100,0x104,... one per cycle.
REQ-034 insn_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, imem_req low thereafter, insn/insn_pc held at 0x100; release -> 4 entries drain, fetch resumes at 0x110.
REQ-035 Redirect to 0x203 while 2 entries queued and one in-flight -> insn_valid=0 that cycle, stale response dropped, next request 0x200, next insn_pc 0x200.
REQ-036 Redirect to 0xFFFF_FFF8, insn_ready=1 -> insn_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-037 rst pulsed one cycle mid-stream -> outputs per REQ-026, no stale instruction delivered, fetch restarts at RESET_PC.
REQ-038 With INSN_PREFETCH_STALLCNT_EN: stall_cnt=2 at first insn_valid after reset; +1 per redirect bubble cycle; compiles without the macro with no stall_cnt port.
